// File: rtl/demux_pkg.sv
// Shared types and defaults for the buffered 1:2 word demultiplexer.
package demux_pkg;

  localparam int WIDTH = 32;

  typedef logic [WIDTH-1:0] word_t;

  typedef enum logic {
    DEST_OUT0 = 1'b0,
    DEST_OUT1 = 1'b1
  } dest_e;

endpackage : demux_pkg

// File: rtl/demux1x2_32b_buf_if.sv
// Handshake bundle for the demux: one input stream and two output streams.
// The master side is the producer/consumers; the slave side is the demux.
interface demux1x2_32b_buf_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
);

  localparam int CW = $clog2(DEPTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_sel;

  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out0_data;
  logic [CW-1:0]    out0_count;

  logic             out1_valid;
  logic             out1_ready;
  logic [WIDTH-1:0] out1_data;
  logic [CW-1:0]    out1_count;

  modport master (
    output in_valid, in_data, in_sel, out0_ready, out1_ready,
    input  in_ready, out0_valid, out0_data, out0_count,
           out1_valid, out1_data, out1_count
  );

  modport slave (
    input  in_valid, in_data, in_sel, out0_ready, out1_ready,
    output in_ready, out0_valid, out0_data, out0_count,
           out1_valid, out1_data, out1_count
  );

endinterface : demux1x2_32b_buf_if

// File: rtl/fifo_sync_buf.sv
// Small synchronous FIFO with registered occupancy. Head word is read straight
// from storage, so a pushed word is visible no earlier than the next cycle.
module fifo_sync_buf #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Status flags come only from the registered count.
  assign full      = (count_q == CNT_FULL);
  assign empty     = (count_q == {CW{1'b0}});
  assign count     = count_q;
  assign head_data = mem_q[rptr_q];

  // Next-state: write at wptr, advance rptr on pop, track occupancy separately.
  always_comb begin
    mem_d     = mem_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count_q;
    push_ok_s = push & ~full;
    pop_ok_s  = pop & ~empty;

    if (push_ok_s) begin
      mem_d[wptr_q] = push_data;
      wptr_d        = wptr_q + PTR_ONE;
    end else begin
      wptr_d = wptr_q;
    end

    if (pop_ok_s) begin
      rptr_d = rptr_q + PTR_ONE;
    end else begin
      rptr_d = rptr_q;
    end

    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // State registers; reset empties the FIFO and clears storage.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      wptr_q  <= {PW{1'b0}};
      rptr_q  <= {PW{1'b0}};
      count_q <= {CW{1'b0}};
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

endmodule : fifo_sync_buf

// File: rtl/demux1x2_32b_buf.sv
// Buffered 1:2 word demultiplexer. Each destination has its own FIFO so a
// stalled consumer only blocks words addressed to it.
module demux1x2_32b_buf
  import demux_pkg::*;
#(
  parameter int WIDTH = demux_pkg::WIDTH,
  parameter int DEPTH = 2
) (
  input logic              clk,
  input logic              n_rst,
  demux1x2_32b_buf_if.slave bus
);

  localparam int CW = $clog2(DEPTH + 1);

  dest_e            dest_s;
  logic             in_ready_s;
  logic             push0_s, push1_s;
  logic             pop0_s, pop1_s;
  logic             full0_s, full1_s;
  logic             empty0_s, empty1_s;
  logic [WIDTH-1:0] head0_s, head1_s;
  logic [CW-1:0]    count0_s, count1_s;

  assign dest_s = dest_e'(bus.in_sel);

  // Steering: ready follows the selected FIFO's full flag only; push/pop gating.
  always_comb begin
    in_ready_s = 1'b0;
    push0_s    = 1'b0;
    push1_s    = 1'b0;
    case (dest_s)
      DEST_OUT0: in_ready_s = ~full0_s;
      DEST_OUT1: in_ready_s = ~full1_s;
      default:   in_ready_s = 1'b0;
    endcase
    if (bus.in_valid && in_ready_s) begin
      push0_s = (dest_s == DEST_OUT0);
      push1_s = (dest_s == DEST_OUT1);
    end else begin
      push0_s = 1'b0;
      push1_s = 1'b0;
    end
    pop0_s = bus.out0_ready & ~empty0_s;
    pop1_s = bus.out1_ready & ~empty1_s;
  end

  fifo_sync_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
    .clk       (clk),
    .n_rst     (n_rst),
    .push      (push0_s),
    .push_data (bus.in_data),
    .full      (full0_s),
    .pop       (pop0_s),
    .head_data (head0_s),
    .empty     (empty0_s),
    .count     (count0_s)
  );

  fifo_sync_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
    .clk       (clk),
    .n_rst     (n_rst),
    .push      (push1_s),
    .push_data (bus.in_data),
    .full      (full1_s),
    .pop       (pop1_s),
    .head_data (head1_s),
    .empty     (empty1_s),
    .count     (count1_s)
  );

  assign bus.in_ready   = in_ready_s;
  assign bus.out0_valid = ~empty0_s;
  assign bus.out0_data  = head0_s;
  assign bus.out0_count = count0_s;
  assign bus.out1_valid = ~empty1_s;
  assign bus.out1_data  = head1_s;
  assign bus.out1_count = count1_s;

endmodule : demux1x2_32b_buf

// File: tb/tb_demux1x2_32b_buf.sv
// Bench for the buffered 1:2 demux: queue-based model checked every falling
// edge, plus directed scenarios with literal expectations.
module tb_demux1x2_32b_buf;
  import demux_pkg::*;

  localparam int DEPTH = 2;

  logic clk;
  logic n_rst;
  int   pass_cnt;
  int   total_cnt;

  demux1x2_32b_buf_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  demux1x2_32b_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end else begin
      pass_cnt++;
    end
  endtask

  // Reference model: one queue per output.
  word_t q0[$];
  word_t q1[$];

  // Compare outputs against the model, then apply the transfers the next
  // rising edge will perform (inputs are stable from posedge+1 to posedge).
  always @(negedge clk) begin
    if (!n_rst) begin
      q0.delete();
      q1.delete();
      chk("rst_v0", {63'd0, bus.out0_valid}, 64'd0);
      chk("rst_v1", {63'd0, bus.out1_valid}, 64'd0);
      chk("rst_c0", {62'd0, bus.out0_count}, 64'd0);
      chk("rst_c1", {62'd0, bus.out1_count}, 64'd0);
      chk("rst_rdy", {63'd0, bus.in_ready}, 64'd1);
    end else begin
      bit push;
      int sz_sel;
      chk("v0", {63'd0, bus.out0_valid}, {63'd0, q0.size() != 0});
      chk("v1", {63'd0, bus.out1_valid}, {63'd0, q1.size() != 0});
      chk("c0", {62'd0, bus.out0_count}, 64'(q0.size()));
      chk("c1", {62'd0, bus.out1_count}, 64'(q1.size()));
      if (q0.size() != 0) chk("d0", {32'd0, bus.out0_data}, {32'd0, q0[0]});
      if (q1.size() != 0) chk("d1", {32'd0, bus.out1_data}, {32'd0, q1[0]});
      sz_sel = bus.in_sel ? q1.size() : q0.size();
      chk("rdy", {63'd0, bus.in_ready}, {63'd0, sz_sel < DEPTH});
      push = bus.in_valid && (sz_sel < DEPTH);
      if (bus.out0_ready && q0.size() != 0) void'(q0.pop_front());
      if (bus.out1_ready && q1.size() != 0) void'(q1.pop_front());
      if (push) begin
        if (bus.in_sel) q1.push_back(bus.in_data);
        else            q0.push_back(bus.in_data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic [31:0] d,
                       input logic r0, input logic r1);
    bus.in_valid   = v;
    bus.in_sel     = s;
    bus.in_data    = d;
    bus.out0_ready = r0;
    bus.out1_ready = r1;
  endtask

  word_t got[$];

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    n_rst     = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

    // Reset with random inputs for 3 cycles
    for (int i = 0; i < 3; i++) begin
      drive(1'($urandom), 1'($urandom), $urandom, 1'($urandom), 1'($urandom));
      tick();
    end
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    settle();
    chk("rst_rdy_sel0", {63'd0, bus.in_ready}, 64'd1);
    bus.in_sel = 1'b1;
    settle();
    chk("rst_rdy_sel1", {63'd0, bus.in_ready}, 64'd1);
    tick();
    n_rst = 1'b1;
    tick();

    // Single routing
    drive(1'b1, 1'b0, 32'hDEADBEEF, 1'b1, 1'b1);
    settle();
    chk("route_rdy", {63'd0, bus.in_ready}, 64'd1);
    chk("route_nofall", {63'd0, bus.out0_valid}, 64'd0);
    tick();
    chk("route_v0", {63'd0, bus.out0_valid}, 64'd1);
    chk("route_d0", {32'd0, bus.out0_data}, 64'hDEADBEEF);
    chk("route_v1_idle", {63'd0, bus.out1_valid}, 64'd0);
    drive(1'b1, 1'b1, 32'h12345678, 1'b1, 1'b1);
    tick();
    chk("route_v0_gone", {63'd0, bus.out0_valid}, 64'd0);
    chk("route_v1", {63'd0, bus.out1_valid}, 64'd1);
    chk("route_d1", {32'd0, bus.out1_data}, 64'h12345678);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    tick();

    // Backpressure / full
    drive(1'b1, 1'b0, 32'h1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 32'h2, 1'b0, 1'b0);
    tick();
    chk("bp_c0_full", {62'd0, bus.out0_count}, 64'd2);
    drive(1'b1, 1'b0, 32'h3, 1'b0, 1'b0);
    settle();
    chk("bp_rdy_full", {63'd0, bus.in_ready}, 64'd0);
    tick();
    chk("bp_c0_hold", {62'd0, bus.out0_count}, 64'd2);
    drive(1'b1, 1'b1, 32'hAA, 1'b0, 1'b0);
    settle();
    chk("bp_rdy_other", {63'd0, bus.in_ready}, 64'd1);
    tick();
    chk("bp_c1", {62'd0, bus.out1_count}, 64'd1);
    drive(1'b1, 1'b0, 32'h3, 1'b1, 1'b0);
    settle();
    chk("bp_no_passthru", {63'd0, bus.in_ready}, 64'd0);
    chk("bp_head1", {32'd0, bus.out0_data}, 64'h1);
    tick();
    chk("bp_head2", {32'd0, bus.out0_data}, 64'h2);
    chk("bp_c0_one", {62'd0, bus.out0_count}, 64'd1);
    settle();
    chk("bp_rdy_free", {63'd0, bus.in_ready}, 64'd1);
    tick();
    chk("bp_head3", {32'd0, bus.out0_data}, 64'h3);
    chk("bp_c0_pp", {62'd0, bus.out0_count}, 64'd1);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    tick();
    tick();

    // Simultaneous push and pop at count0 = 1
    drive(1'b1, 1'b0, 32'h44, 1'b0, 1'b0);
    tick();
    chk("pp_c0_a", {62'd0, bus.out0_count}, 64'd1);
    drive(1'b1, 1'b0, 32'h55, 1'b1, 1'b0);
    tick();
    chk("pp_c0_b", {62'd0, bus.out0_count}, 64'd1);
    chk("pp_head", {32'd0, bus.out0_data}, 64'h55);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    tick();

    // Wrap-around: 10 words to out1 with random consumer readiness
    got.delete();
    for (int sent = 0; sent < 10; ) begin
      drive(1'b1, 1'b1, 32'(sent), 1'b1, 1'($urandom));
      settle();
      if (bus.out1_valid && bus.out1_ready) got.push_back(bus.out1_data);
      if (bus.in_ready) sent++;
      tick();
    end
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    for (int i = 0; i < 40 && got.size() < 10; i++) begin
      settle();
      if (bus.out1_valid && bus.out1_ready) got.push_back(bus.out1_data);
      tick();
    end
    chk("wrap_cnt", 64'(got.size()), 64'd10);
    for (int i = 0; i < 10; i++) begin
      word_t w;
      w = (i < got.size()) ? got[i] : 32'hFFFFFFFF;
      chk("wrap_order", {32'd0, w}, 64'(i));
    end

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom), 1'($urandom), $urandom, 1'($urandom), 1'($urandom));
      tick();
    end

    // Mid-operation asynchronous reset
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    tick();
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'(i), 32'hC0DE0000 + 32'(i), 1'b0, 1'b0);
      tick();
    end
    chk("mr_c0_full", {62'd0, bus.out0_count}, 64'd2);
    chk("mr_c1_full", {62'd0, bus.out1_count}, 64'd2);
    drive(1'b1, 1'b0, 32'hBAD0BAD0, 1'b1, 1'b1);
    @(posedge clk);
    #3;
    n_rst = 1'b0;
    #1;
    chk("mr_v0_drop", {63'd0, bus.out0_valid}, 64'd0);
    chk("mr_v1_drop", {63'd0, bus.out1_valid}, 64'd0);
    chk("mr_c0_zero", {62'd0, bus.out0_count}, 64'd0);
    chk("mr_c1_zero", {62'd0, bus.out1_count}, 64'd0);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    tick();
    tick();
    n_rst = 1'b1;
    tick();
    chk("mr_post_v0", {63'd0, bus.out0_valid}, 64'd0);
    chk("mr_post_v1", {63'd0, bus.out1_valid}, 64'd0);
    tick();
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_demux1x2_32b_buf
